dmem_block_responder: RTL and testbench

//  Data-memory side of the cache<->memory block interface: answers block reads and

---
 rtl/dmem_block_responder_pkg.sv | 23 ++
 rtl/dmem_block_responder_if.sv | 26 ++
 rtl/dmem_latency_counter.sv | 30 +++
 rtl/dmem_block_responder.sv | 84 ++++++++
 tb/tb_dmem_block_responder.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/dmem_block_responder_pkg.sv
// rtl/dmem_block_responder_pkg.sv - shared widths, state/op encodings for the dmem block responder
package dmem_block_responder_pkg;

    localparam int DMEM_ADDR_W = 6;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } dmem_op_t;

    // A simultaneous read+write request is treated as a write.
    function automatic dmem_op_t decode_op(input logic rd, input logic wr);
        return (wr || !rd) ? OP_WRITE : OP_READ;
    endfunction

endpackage

// File: rtl/dmem_block_responder_if.sv
// rtl/dmem_block_responder_if.sv - cache<->memory block bus with master/slave modports
interface dmem_block_responder_if
    import dmem_block_responder_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) ();

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;
    logic              mem_busywait;

    modport master (
        output mem_read, mem_write, mem_address, mem_writedata,
        input  mem_readdata, mem_busywait
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_writedata,
        output mem_readdata, mem_busywait
    );

endinterface

// File: rtl/dmem_latency_counter.sv
// rtl/dmem_latency_counter.sv - load/decrement down-counter timing one memory access
module dmem_latency_counter #(
    parameter int LATENCY = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    localparam int CNT_W = $clog2(LATENCY);
    // The accept cycle and the final BUSY cycle are not counted down.
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 2);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/dmem_block_responder.sv
// rtl/dmem_block_responder.sv - block memory answering dcache reads/write-backs with fixed latency
module dmem_block_responder
    import dmem_block_responder_pkg::*;
#(
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int LATENCY = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    dmem_block_responder_if.slave mem
);

    localparam int DEPTH = 2 ** ADDR_W;

    dmem_state_t       r_state;
    dmem_op_t          r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_req;
    logic w_accept;
    logic w_cnt_zero;

    assign w_req    = mem.mem_read | mem.mem_write;
    assign w_accept = (r_state == ST_IDLE) && w_req;

    dmem_latency_counter #(
        .LATENCY (LATENCY)
    ) u_latency_counter (
        .clock  (clock),
        .reset  (reset),
        .i_load (w_accept),
        .i_dec  (r_state == ST_BUSY),
        .o_zero (w_cnt_zero)
    );

    // Busywait rises combinationally so the cache stalls in the request cycle itself.
    assign mem.mem_busywait = w_accept || (r_state == ST_BUSY);
    assign mem.mem_readdata = r_rdata;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_op    <= OP_READ;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_op    <= decode_op(mem.mem_read, mem.mem_write);
                        r_addr  <= mem.mem_address;
                        r_wdata <= mem.mem_writedata;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_DONE;
                        if (r_op == OP_WRITE) begin
                            r_mem[r_addr] <= r_wdata;
                        end else begin
                            r_rdata <= r_mem[r_addr];
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_block_responder.sv
// tb/tb_dmem_block_responder.sv - randomized self-checking bench against a block-level memory model
module tb_dmem_block_responder;

    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 32;
    localparam int LATENCY = 5;
    localparam int DEPTH   = 2 ** ADDR_W;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    dmem_block_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

    dmem_block_responder #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .LATENCY (LATENCY)
    ) dut (
        .clock (clock),
        .reset (reset),
        .mem   (mem_bus)
    );

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] model_rdata;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_rdata = '0;
    endtask

    task automatic drive_idle();
        mem_bus.mem_read      = 1'b0;
        mem_bus.mem_write     = 1'b0;
        mem_bus.mem_address   = '0;
        mem_bus.mem_writedata = '0;
    endtask

    // Called in the first half of a cycle; returns in the first half of the cycle after DONE.
    task automatic access(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data, input bit scramble, input string tag);
        mem_bus.mem_read      = rd;
        mem_bus.mem_write     = wr;
        mem_bus.mem_address   = addr;
        mem_bus.mem_writedata = data;
        for (int c = 0; c <= LATENCY; c++) begin
            @(negedge clock);
            expect_eq({tag, "_busy"}, {31'b0, mem_bus.mem_busywait}, (c < LATENCY) ? 32'd1 : 32'd0);
            if (c == LATENCY) begin
                if (wr) model_mem[addr] = data;
                else if (rd) model_rdata = model_mem[addr];
                expect_eq({tag, "_rdata"}, mem_bus.mem_readdata, model_rdata);
            end
            if (scramble && c >= 1 && c < LATENCY) begin
                mem_bus.mem_address   = ADDR_W'($urandom);
                mem_bus.mem_writedata = $urandom;
                mem_bus.mem_read      = 1'($urandom);
                mem_bus.mem_write     = 1'($urandom);
            end
        end
        drive_idle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        drive_idle();
        model_reset();

        // Reset held two cycles
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        expect_eq("rst_busy", {31'b0, mem_bus.mem_busywait}, 32'd0);
        expect_eq("rst_rdata", mem_bus.mem_readdata, 32'd0);
        @(posedge clock);
        #1;
        access(1'b1, 1'b0, 6'h3F, 32'h0, 1'b0, "rd3f");

        // Write then read back
        access(1'b0, 1'b1, 6'h05, 32'hDEADBEEF, 1'b0, "wr05");
        access(1'b1, 1'b0, 6'h05, 32'h0, 1'b0, "rd05");

        // Miss-with-dirty: write-back then refill
        access(1'b0, 1'b1, 6'h2A, 32'hA5A55A5A, 1'b0, "pre2a");
        access(1'b0, 1'b1, 6'h12, 32'h12345678, 1'b0, "wb12");
        access(1'b1, 1'b0, 6'h2A, 32'h0, 1'b0, "rf2a");
        access(1'b1, 1'b0, 6'h12, 32'h0, 1'b0, "rd12");

        // Inputs scrambled during BUSY
        access(1'b0, 1'b1, 6'h33, 32'h0BADF00D, 1'b1, "scrw");
        access(1'b1, 1'b0, 6'h33, 32'h0, 1'b1, "scrr");

        // Read and write together: write wins, readdata untouched
        access(1'b1, 1'b1, 6'h07, 32'h01020304, 1'b0, "both07");
        access(1'b1, 1'b0, 6'h07, 32'h0, 1'b0, "rd07");

        // Random traffic over a small address window to force hits
        for (int n = 0; n < 30; n++) begin
            int op;
            op = int'($urandom_range(0, 2));
            access(op != 1, op != 0, ADDR_W'($urandom_range(0, 11)), $urandom,
                   1'($urandom_range(0, 1)), "rand");
        end

        // Reset in the third BUSY cycle of a write
        mem_bus.mem_write     = 1'b1;
        mem_bus.mem_address   = 6'h09;
        mem_bus.mem_writedata = 32'hCAFEF00D;
        @(negedge clock);
        expect_eq("abort_busy0", {31'b0, mem_bus.mem_busywait}, 32'd1);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        drive_idle();
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        expect_eq("abort_busy", {31'b0, mem_bus.mem_busywait}, 32'd0);
        expect_eq("abort_rdata", mem_bus.mem_readdata, 32'd0);
        @(posedge clock);
        #1;
        access(1'b1, 1'b0, 6'h09, 32'h0, 1'b0, "rd09");
        access(1'b1, 1'b0, 6'h05, 32'h0, 1'b0, "rd05z");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
